ps2_frame_receiver: RTL and testbench
=====================================

Name: ps2_frame_receiver

Overview:
Parametrised PS/2-style serial frame receiver that replaces the fixed 11-bit shift-and-count deserializer. It consumes one bit per `sample_ready` strobe from the edge detector and frames start/data/parity/stop with an explicit FSM. It checks odd parity and the stop bit, and aborts stalled frames with a watchdog. Good bytes are buffered in a small FIFO with a valid/ready output toward the keyboard decoder.

Parameters:
DATA_W, 8, data bits per frame, LSB first
PARITY_EN, 1, 1 = expect and check an odd-parity bit after data; 0 = no parity bit
FIFO_DEPTH, 4, output FIFO entries; power of two, >= 2
TIMEOUT_CYCLES, 50000, clk cycles allowed between strobes inside a frame

Ports:
clk  in  1  system clock
reset_n  in  1  reset: asynchronous, active-low
sample_ready  in  1  one-cycle strobe: serial_data holds a valid bit this cycle
serial_data  in  1  sampled PS/2 data line
out_valid  out  1  FIFO non-empty
out_ready  in  1  consumer accepts out_data this cycle
out_data  out  DATA_W  head-of-FIFO byte
frame_error  out  1  one-cycle pulse: bad stop bit or timeout
parity_error  out  1  one-cycle pulse: parity mismatch
overflow  out  1  one-cycle pulse: good frame dropped because FIFO full

Behaviour:
- Reset (async, `reset_n` = 0):
  - FSM to IDLE; shift register, bit counter, timeout counter, FIFO pointers and count cleared.
  - `out_valid`, `out_data`, `frame_error`, `parity_error`, `overflow` all 0.
  - Reset mid-frame discards the partial frame and all FIFO contents.
- FSM states are IDLE, DATA, PARITY, STOP. All transitions happen only on cycles with `sample_ready` = 1, except timeout.
  - IDLE: `serial_data` = 0 goes to DATA, bit counter = 0. `serial_data` = 1 is ignored and the FSM stays in IDLE.
  - DATA: shift `serial_data` into bit `[cnt]`, LSB first. When cnt = DATA_W-1, go to PARITY if PARITY_EN, otherwise to STOP.
  - PARITY: store the parity bit, go to STOP.
  - STOP: evaluate the frame and go to IDLE.
- Frame evaluation at the STOP strobe, in priority order:
  - `serial_data` = 0: pulse `frame_error`, drop the frame.
  - PARITY_EN and (XOR of data bits ^ parity bit) != 1: pulse `parity_error`, drop the frame.
  - FIFO full, with no pop in the same cycle: pulse `overflow`, drop the frame.
  - Otherwise push the data to the FIFO.
  - Error and overflow pulses are registered and high in the cycle after the STOP strobe.
  - At most one of `frame_error`, `parity_error`, `overflow` is high in any cycle.
- Timeout:
  - The counter is cleared on every `sample_ready` and while in IDLE; it increments each cycle otherwise.
  - When it reaches TIMEOUT_CYCLES-1, the FSM goes to IDLE, `frame_error` pulses next cycle, and the partial frame is dropped.
  - A strobe in the same cycle as the timeout is ignored.
- Output handshake:
  - A pop happens when `out_valid` & `out_ready`.
  - `out_data` and `out_valid` are registered FIFO-head views. `out_data` is stable while `out_valid` = 1 and no pop.
  - A pushed byte is visible at the head starting the cycle after the STOP strobe, when the FIFO was empty: 1-cycle latency.
  - Simultaneous push and pop while full is accepted: count is unchanged, no overflow.
  - Pop while empty is ignored.
- Widths:
  - FIFO count is clog2(FIFO_DEPTH)+1 bits; pointers wrap modulo FIFO_DEPTH.
  - Timeout counter is clog2(TIMEOUT_CYCLES) bits; bit counter is clog2(DATA_W) bits.
- `sample_ready` high on consecutive cycles is legal; each strobe is one bit.

Decomposition:
- Shared package `ps2_pkg`:
  - FSM state enum: IDLE, DATA, PARITY, STOP.
  - Default constants: PS2_DATA_W = 8, PS2_TIMEOUT_CYCLES.
  - Odd-parity function.
- One sub-module, `sync_fifo`, parametrised by WIDTH and DEPTH:
  - push/pop/full/empty interface, registered head output.
  - Reused later by the scancode decoder.

Test Plan:
- Frame 0x1C, no backpressure: bits 0, 0,0,1,1,1,0,0,0, parity 0, stop 1 (out_ready = 1) -> `out_valid` for 1 cycle with `out_data` = 0x1C, no error pulses.
- Frame 0x1C sent with parity 1 -> `parity_error` pulses once; `out_valid` stays 0. Frame 0xF0 with stop bit 0 -> `frame_error` pulses once; nothing pushed.
- Timeout recovery: start plus 3 data bits, then no strobes for TIMEOUT_CYCLES (bench TIMEOUT_CYCLES = 20) -> `frame_error` pulses. A following frame 0x5A with parity 1 is received as 0x5A.
- Overflow: FIFO_DEPTH = 2, out_ready = 0, frames 0x11, 0x22, 0x33 (parity 1 each) -> `overflow` pulses on the third frame. Then out_ready = 1 drains 0x11, then 0x22, then `out_valid` = 0.
- Simultaneous push and pop at full: FIFO full of 0x11, 0x22; out_ready = 1 in the STOP-strobe cycle of frame 0x33 -> no overflow, drain yields 0x22 then 0x33.
- Idle glitch and mid-frame reset:
  - `serial_data` = 1 strobes in IDLE -> no state change.
  - `reset_n` pulsed low after 5 data bits -> all outputs 0; the next full frame 0xAA (parity 1) is received correctly.

Source files
------------

// File: rtl/ps2_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 receive path: frame FSM state encoding,
// default frame/timeout constants and the odd-parity check helper.
// ---------------------------------------------------------------------------
package ps2_pkg;

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      PARITY,
      STOP
   } ps2_state_e;

   localparam int unsigned PS2_DATA_W         = 8;
   localparam int unsigned PS2_TIMEOUT_CYCLES = 50000;

   // Returns 1 when data plus parity bit hold an odd number of ones.
   // Callers zero-extend narrower data; zero bits do not change the XOR.
   function automatic logic odd_parity_ok(input logic [31:0] data, input logic parity);
      return (^data) ^ parity;
   endfunction

endpackage

// File: rtl/ps2_frame_receiver_sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with a registered head view.
//   clk, reset_n : clock, asynchronous active-low reset
//   push         : write push_data (ignored when full, unless popping too)
//   push_data    : WIDTH-bit write data
//   pop          : remove the head entry (ignored when empty)
//   full         : DEPTH entries stored
//   empty        : no entries stored (registered)
//   head_data    : registered copy of the oldest entry, 0 when empty
// ---------------------------------------------------------------------------
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head_data
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_q, rd_q, rd_next;
   logic [CNT_W-1:0] count_q, count_d, remaining;
   logic [WIDTH-1:0] head_q, head_d;
   logic             valid_q;
   logic             pop_ok, push_ok;

   assign full      = (count_q == CNT_W'(DEPTH));
   assign empty     = !valid_q;
   assign head_data = head_q;

   // The head register is loaded with whatever will be at rd_next after
   // this cycle's pop; if the FIFO drains to exactly zero before the push,
   // the pushed word itself becomes the head.
   always_comb begin
      pop_ok    = pop && (count_q != '0);
      push_ok   = push && (!full || pop_ok);
      rd_next   = rd_q + PTR_W'(pop_ok);
      remaining = count_q - CNT_W'(pop_ok);
      count_d   = remaining + CNT_W'(push_ok);
      head_d    = '0;
      if (count_d == '0) begin
         head_d = '0;
      end else if (remaining == '0) begin
         head_d = push_data;
      end else begin
         head_d = mem[rd_next];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
         head_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         if (push_ok) begin
            wr_q <= wr_q + PTR_W'(1);
         end
         rd_q    <= rd_next;
         count_q <= count_d;
         head_q  <= head_d;
         valid_q <= (count_d != '0);
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_q] <= push_data;
      end
   end

endmodule

// File: rtl/ps2_frame_receiver.sv
// ---------------------------------------------------------------------------
// ps2_frame_receiver
// Frames PS/2 serial bits (start, DATA_W data LSB first, optional odd
// parity, stop), checks parity/stop, aborts stalled frames and buffers good
// bytes in a FIFO toward the keyboard decoder.
//   clk, reset_n  : clock, asynchronous active-low reset
//   sample_ready  : one-cycle strobe, serial_data is a valid bit
//   serial_data   : sampled PS/2 data line
//   out_valid     : FIFO non-empty
//   out_ready     : consumer accepts out_data
//   out_data      : head-of-FIFO byte
//   frame_error   : pulse, bad stop bit or timeout
//   parity_error  : pulse, parity mismatch
//   overflow      : pulse, good frame dropped with FIFO full
// ---------------------------------------------------------------------------
module ps2_frame_receiver
   import ps2_pkg::*;
#(
   parameter int unsigned DATA_W         = PS2_DATA_W,
   parameter bit          PARITY_EN      = 1'b1,
   parameter int unsigned FIFO_DEPTH     = 4,
   parameter int unsigned TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              sample_ready,
   input  logic              serial_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              frame_error,
   output logic              parity_error,
   output logic              overflow
);

   localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam int unsigned TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   ps2_state_e        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              par_q, par_d;
   logic [TO_W-1:0]   to_q, to_d;
   logic              fe_q, fe_d, pe_q, pe_d, ov_q, ov_d;
   logic              timeout, push, pop, fifo_full, fifo_empty;

   assign out_valid    = !fifo_empty;
   assign pop          = out_valid && out_ready;
   assign frame_error  = fe_q;
   assign parity_error = pe_q;
   assign overflow     = ov_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      par_d   = par_q;
      fe_d    = 1'b0;
      pe_d    = 1'b0;
      ov_d    = 1'b0;
      push    = 1'b0;
      timeout = (state_q != IDLE) && (to_q == TO_W'(TIMEOUT_CYCLES - 1));
      to_d    = (state_q == IDLE || sample_ready) ? '0 : to_q + TO_W'(1);

      // Timeout takes precedence: a strobe landing in the same cycle is dropped.
      if (timeout) begin
         state_d = IDLE;
         fe_d    = 1'b1;
         to_d    = '0;
      end else if (sample_ready) begin
         unique case (state_q)
            IDLE: begin
               if (!serial_data) begin
                  state_d = DATA;
                  cnt_d   = '0;
                  data_d  = '0;
               end
            end
            DATA: begin
               data_d[cnt_q] = serial_data;
               if (cnt_q == CNT_W'(DATA_W - 1)) begin
                  state_d = PARITY_EN ? PARITY : STOP;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            PARITY: begin
               par_d   = serial_data;
               state_d = STOP;
            end
            STOP: begin
               state_d = IDLE;
               if (!serial_data) begin
                  fe_d = 1'b1;
               end else if (PARITY_EN && !odd_parity_ok(32'(data_q), par_q)) begin
                  pe_d = 1'b1;
               end else if (fifo_full && !pop) begin
                  ov_d = 1'b1;
               end else begin
                  push = 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         data_q  <= '0;
         par_q   <= 1'b0;
         to_q    <= '0;
         fe_q    <= 1'b0;
         pe_q    <= 1'b0;
         ov_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         par_q   <= par_d;
         to_q    <= to_d;
         fe_q    <= fe_d;
         pe_q    <= pe_d;
         ov_q    <= ov_d;
      end
   end

   sync_fifo #(
      .WIDTH (DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (push),
      .push_data (data_q),
      .pop       (pop),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .head_data (out_data)
   );

endmodule

// File: tb/tb_ps2_frame_receiver.sv
// ---------------------------------------------------------------------------
// tb_ps2_frame_receiver
// Directed bench for ps2_frame_receiver (FIFO_DEPTH 2, TIMEOUT_CYCLES 20).
// ---------------------------------------------------------------------------
module tb_ps2_frame_receiver;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       sample_ready = 1'b0;
   logic       serial_data = 1'b1;
   logic       out_valid;
   logic       out_ready = 1'b1;
   logic [7:0] out_data;
   logic       frame_error, parity_error, overflow;

   int checks = 0;
   int errors = 0;
   int fe_cnt = 0, pe_cnt = 0, ov_cnt = 0, excl_viol = 0;
   logic [7:0] popped [$];

   always #5 clk = ~clk;

   ps2_frame_receiver #(
      .DATA_W         (8),
      .PARITY_EN      (1'b1),
      .FIFO_DEPTH     (2),
      .TIMEOUT_CYCLES (20)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .sample_ready (sample_ready),
      .serial_data  (serial_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .frame_error  (frame_error),
      .parity_error (parity_error),
      .overflow     (overflow)
   );

   always @(negedge clk) begin
      if (reset_n) begin
         if (frame_error)  fe_cnt++;
         if (parity_error) pe_cnt++;
         if (overflow)     ov_cnt++;
         if (int'(frame_error) + int'(parity_error) + int'(overflow) > 1) excl_viol++;
         if (out_valid && out_ready) popped.push_back(out_data);
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   // All stimulus tasks start and end just after a rising edge.
   task automatic send_bit(input logic b);
      @(posedge clk); #1;
      sample_ready = 1'b1;
      serial_data  = b;
      @(posedge clk); #1;
      sample_ready = 1'b0;
      serial_data  = 1'b1;
   endtask

   task automatic send_head(input logic [7:0] d, input logic p);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
      send_bit(p);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
      send_head(d, p);
      send_bit(s);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   int fe0, pe0, ov0, pb, k;

   initial begin
      // Reset state
      idle(3);
      @(negedge clk);
      check("rst_valid", 32'(out_valid), 0);
      check("rst_data", 32'(out_data), 0);
      check("rst_errs", {29'd0, frame_error, parity_error, overflow}, 0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      idle(2);

      // Good frame 0x1C, out_ready = 1: visible one cycle after the STOP strobe
      fe0 = fe_cnt; pe0 = pe_cnt; ov0 = ov_cnt; pb = popped.size();
      send_frame(8'h1C, 1'b0, 1'b1);
      @(negedge clk);
      check("t1_valid_lat", 32'(out_valid), 1);
      check("t1_data", 32'(out_data), 32'h1C);
      @(negedge clk);
      check("t1_valid_after", 32'(out_valid), 0);
      idle(3);
      check("t1_pops", popped.size() - pb, 1);
      check("t1_errs", (fe_cnt - fe0) + (pe_cnt - pe0) + (ov_cnt - ov0), 0);

      // Parity error, then stop-bit error
      pb = popped.size(); fe0 = fe_cnt; pe0 = pe_cnt;
      send_frame(8'h1C, 1'b1, 1'b1);
      idle(3);
      check("t2_pe", pe_cnt - pe0, 1);
      check("t2_valid", 32'(out_valid), 0);
      send_frame(8'hF0, 1'b1, 1'b0);
      idle(3);
      check("t2_fe", fe_cnt - fe0, 1);
      check("t2_pe_once", pe_cnt - pe0, 1);
      check("t2_pops", popped.size() - pb, 0);

      // Timeout: start + 3 data bits, then silence
      fe0 = fe_cnt; pb = popped.size();
      send_bit(1'b0);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      k = 0;
      while (!frame_error && k < 40) begin
         @(negedge clk);
         k++;
      end
      check("t3_timeout_cycles", k, 21);
      idle(2);
      check("t3_fe", fe_cnt - fe0, 1);
      send_frame(8'h5A, 1'b1, 1'b1);
      idle(3);
      check("t3_pops", popped.size() - pb, 1);
      if (popped.size() > pb) check("t3_data", 32'(popped[pb]), 32'h5A);

      // Overflow with FIFO_DEPTH 2
      out_ready = 1'b0;
      ov0 = ov_cnt; pb = popped.size();
      send_frame(8'h11, 1'b1, 1'b1);
      idle(2);
      send_frame(8'h22, 1'b1, 1'b1);
      idle(2);
      check("t4_ov_none", ov_cnt - ov0, 0);
      send_frame(8'h33, 1'b1, 1'b1);
      idle(2);
      check("t4_ov", ov_cnt - ov0, 1);
      @(negedge clk);
      check("t4_head", 32'(out_data), 32'h11);
      @(posedge clk); #1;
      out_ready = 1'b1;
      idle(4);
      check("t4_pops", popped.size() - pb, 2);
      if (popped.size() >= pb + 2) begin
         check("t4_pop0", 32'(popped[pb]), 32'h11);
         check("t4_pop1", 32'(popped[pb+1]), 32'h22);
      end
      check("t4_empty", 32'(out_valid), 0);

      // Push and pop together while full
      out_ready = 1'b0;
      ov0 = ov_cnt; pb = popped.size();
      send_frame(8'h11, 1'b1, 1'b1);
      send_frame(8'h22, 1'b1, 1'b1);
      send_head(8'h33, 1'b1);
      @(posedge clk); #1;
      sample_ready = 1'b1;
      serial_data  = 1'b1;
      out_ready    = 1'b1;
      @(posedge clk); #1;
      sample_ready = 1'b0;
      out_ready    = 1'b0;
      @(negedge clk);
      check("t5_head", 32'(out_data), 32'h22);
      idle(2);
      check("t5_ov", ov_cnt - ov0, 0);
      out_ready = 1'b1;
      idle(4);
      check("t5_pops", popped.size() - pb, 3);
      if (popped.size() >= pb + 3) begin
         check("t5_pop1", 32'(popped[pb+1]), 32'h22);
         check("t5_pop2", 32'(popped[pb+2]), 32'h33);
      end
      check("t5_empty", 32'(out_valid), 0);

      // Idle strobes with line high are ignored
      fe0 = fe_cnt; pe0 = pe_cnt; pb = popped.size();
      send_bit(1'b1);
      send_bit(1'b1);
      send_bit(1'b1);
      send_frame(8'h1C, 1'b0, 1'b1);
      idle(3);
      check("t6_pops", popped.size() - pb, 1);
      if (popped.size() > pb) check("t6_data", 32'(popped[pb]), 32'h1C);
      check("t6_errs", (fe_cnt - fe0) + (pe_cnt - pe0), 0);

      // Mid-frame reset flushes FIFO and partial frame
      out_ready = 1'b0;
      send_frame(8'h5A, 1'b1, 1'b1);
      idle(2);
      send_bit(1'b0);
      for (int i = 0; i < 5; i++) send_bit(1'b1);
      reset_n = 1'b0;
      #1;
      check("t7_rst_valid", 32'(out_valid), 0);
      check("t7_rst_data", 32'(out_data), 0);
      check("t7_rst_errs", {29'd0, frame_error, parity_error, overflow}, 0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      out_ready = 1'b1;
      idle(2);
      fe0 = fe_cnt; pe0 = pe_cnt; pb = popped.size();
      send_frame(8'hAA, 1'b1, 1'b1);
      idle(3);
      check("t7_pops", popped.size() - pb, 1);
      if (popped.size() > pb) check("t7_data", 32'(popped[pb]), 32'hAA);
      check("t7_errs", (fe_cnt - fe0) + (pe_cnt - pe0), 0);

      check("exclusive_pulses", excl_viol, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got timeout expected finish");
      $fatal(1);
   end

endmodule
